// File: rtl/clause_array_ctrl.sv
// Controller for a clause array: serial load, indexed readback, BCP to fixpoint and backtrack.
// Every output is a register; the next-state block computes next values for all of them.
module clause_array_ctrl #(
    parameter int NUM_CLAUSES  = 8,
    parameter int NUM_VARS     = 8,
    parameter int WIDTH_C_LEN  = 4,
    parameter int MAX_BCP_ITER = 15
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             load_valid_i,
    output logic                             load_ready_o,
    input  logic [2*NUM_VARS-1:0]            load_clause_i,
    input  logic [WIDTH_C_LEN-1:0]           load_len_i,
    input  logic                             rd_start_i,
    output logic                             rd_valid_o,
    input  logic                             rd_ready_i,
    output logic [2*NUM_VARS-1:0]            rd_clause_o,
    output logic [$clog2(NUM_CLAUSES)-1:0]   rd_index_o,
    input  logic                             bcp_start_i,
    input  logic                             bkt_start_i,
    output logic [NUM_CLAUSES-1:0]           wr_o,
    output logic [NUM_CLAUSES-1:0]           rd_o,
    output logic [2*NUM_VARS-1:0]            clause_o,
    output logic [WIDTH_C_LEN-1:0]           clause_len_o,
    input  logic [2*NUM_VARS-1:0]            arr_clause_i,
    input  logic [3*NUM_VARS-1:0]            arr_var_value_i,
    input  logic                             arr_all_c_sat_i,
    output logic                             apply_impl_o,
    output logic                             apply_bkt_o,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             sat_o,
    output logic                             timeout_o,
    output logic [$clog2(NUM_CLAUSES):0]     fill_o
);
    localparam int IW  = $clog2(NUM_CLAUSES);
    localparam int FW  = IW + 1;
    localparam int ITW = $clog2(MAX_BCP_ITER + 1);
    localparam int CW  = 2 * NUM_VARS;
    localparam int VW  = 3 * NUM_VARS;
    localparam logic [FW-1:0]  FULL   = FW'(NUM_CLAUSES);
    localparam logic [ITW-1:0] MAX_IT = ITW'(MAX_BCP_ITER);

    typedef enum logic [3:0] {
        IDLE, LOAD, RD_REQ, RD_CAP, RD_OUT, BCP_APPLY, BCP_WAIT, BCP_CHECK, BKT
    } state_t;

    state_t                 state, state_n;
    logic [FW-1:0]          fill_n;
    logic [IW-1:0]          idx_n;
    logic [ITW-1:0]         iter, iter_n;
    logic [VW-1:0]          snap, snap_n;
    logic [NUM_CLAUSES-1:0] wr_n, rd_n;
    logic [CW-1:0]          clause_n, rd_clause_n;
    logic [WIDTH_C_LEN-1:0] len_n;
    logic                   impl_n, bkt_n, done_n, sat_n, timeout_n, rd_valid_n;
    logic                   ready_n, busy_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            fill_o       <= '0;
            rd_index_o   <= '0;
            iter         <= '0;
            snap         <= '0;
            wr_o         <= '0;
            rd_o         <= '0;
            clause_o     <= '0;
            clause_len_o <= '0;
            rd_clause_o  <= '0;
            rd_valid_o   <= 1'b0;
            apply_impl_o <= 1'b0;
            apply_bkt_o  <= 1'b0;
            done_o       <= 1'b0;
            sat_o        <= 1'b0;
            timeout_o    <= 1'b0;
            load_ready_o <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            state        <= state_n;
            fill_o       <= fill_n;
            rd_index_o   <= idx_n;
            iter         <= iter_n;
            snap         <= snap_n;
            wr_o         <= wr_n;
            rd_o         <= rd_n;
            clause_o     <= clause_n;
            clause_len_o <= len_n;
            rd_clause_o  <= rd_clause_n;
            rd_valid_o   <= rd_valid_n;
            apply_impl_o <= impl_n;
            apply_bkt_o  <= bkt_n;
            done_o       <= done_n;
            sat_o        <= sat_n;
            timeout_o    <= timeout_n;
            load_ready_o <= ready_n;
            busy_o       <= busy_n;
        end
    end

    always_comb begin
        state_n     = state;
        fill_n      = fill_o;
        idx_n       = rd_index_o;
        iter_n      = iter;
        snap_n      = snap;
        wr_n        = '0;
        rd_n        = '0;
        clause_n    = clause_o;
        len_n       = clause_len_o;
        rd_clause_n = rd_clause_o;
        rd_valid_n  = rd_valid_o;
        impl_n      = 1'b0;
        bkt_n       = 1'b0;
        done_n      = 1'b0;
        sat_n       = sat_o;
        timeout_n   = timeout_o;
        case (state)
            IDLE: begin
                // Lower-priority starts arriving in the same cycle are dropped.
                if (bkt_start_i) begin
                    state_n = BKT;
                    bkt_n   = 1'b1;
                end else if (bcp_start_i) begin
                    state_n   = BCP_APPLY;
                    impl_n    = 1'b1;
                    iter_n    = ITW'(1);
                    sat_n     = 1'b0;
                    timeout_n = 1'b0;
                end else if (rd_start_i) begin
                    if (fill_o == '0) begin
                        done_n = 1'b1;
                    end else begin
                        state_n = RD_REQ;
                        idx_n   = '0;
                        rd_n    = NUM_CLAUSES'(1);
                    end
                end else if (load_valid_i && load_ready_o) begin
                    state_n  = LOAD;
                    wr_n     = NUM_CLAUSES'(1) << fill_o;
                    clause_n = load_clause_i;
                    len_n    = load_len_i;
                    fill_n   = fill_o + FW'(1);
                end
            end
            LOAD:   state_n = IDLE;
            RD_REQ: state_n = RD_CAP;
            RD_CAP: begin
                // Array read data lands one cycle after the read strobe.
                rd_clause_n = arr_clause_i;
                rd_valid_n  = 1'b1;
                state_n     = RD_OUT;
            end
            RD_OUT: begin
                if (rd_ready_i) begin
                    rd_valid_n = 1'b0;
                    if ({1'b0, rd_index_o} == fill_o - FW'(1)) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        idx_n   = rd_index_o + IW'(1);
                        rd_n    = NUM_CLAUSES'(1) << (rd_index_o + IW'(1));
                        state_n = RD_REQ;
                    end
                end
            end
            BCP_APPLY: begin
                snap_n  = arr_var_value_i;
                state_n = BCP_WAIT;
            end
            BCP_WAIT: state_n = BCP_CHECK;
            BCP_CHECK: begin
                if (arr_var_value_i != snap) begin
                    if (iter < MAX_IT) begin
                        state_n = BCP_APPLY;
                        impl_n  = 1'b1;
                        iter_n  = iter + ITW'(1);
                    end else begin
                        state_n   = IDLE;
                        timeout_n = 1'b1;
                        done_n    = 1'b1;
                    end
                end else begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    sat_n   = arr_all_c_sat_i;
                end
            end
            BKT: begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        ready_n = (state_n == IDLE) && (fill_n < FULL);
        busy_n  = (state_n != IDLE);
    end
endmodule
